// File: rtl/sha3_absorb_ctrl.sv
// SHA-3 absorb controller: drains the byte FIFO into rate blocks, applies multi-rate padding,
// and hands blocks to the Keccak core. Optional SHAKE domain separation via SHA3_ABSORB_SHAKE_EN.
module sha3_absorb_ctrl #(
  parameter int unsigned RATE_BYTES = 72,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        msg_len,
`ifdef SHA3_ABSORB_SHAKE_EN
  input  logic                    shake_mode,
`endif
  input  logic [7:0]              fifo_dout,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  output logic [8*RATE_BYTES-1:0] block_data,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic                    block_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DATA_W = 8 * RATE_BYTES;
  localparam int unsigned IDX_W  = $clog2(RATE_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAP  = 3'd2,
    PAD  = 3'd3,
    EMIT = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   byte_idx;
  logic [LEN_W-1:0]   remaining;
  logic [DATA_W-1:0]  cap_block;
  logic [DATA_W-1:0]  pad_block;
  logic [7:0]         ds;

`ifdef SHA3_ABSORB_SHAKE_EN
  logic shake_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shake_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      shake_q <= shake_mode;
    end
  end

  assign ds = shake_q ? 8'h1F : 8'h06;
`else
  assign ds = 8'h06;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (msg_len != '0) ? REQ : PAD;
        end
      end
      REQ: begin
        if (!fifo_empty) begin
          state_d = CAP;
        end
      end
      CAP: begin
        if (byte_idx == IDX_W'(RATE_BYTES - 1)) begin
          state_d = EMIT;
        end else if (remaining == LEN_W'(1)) begin
          state_d = PAD;
        end else begin
          state_d = REQ;
        end
      end
      PAD: state_d = EMIT;
      EMIT: begin
        if (block_ready) begin
          if (block_last) begin
            state_d = IDLE;
          end else begin
            state_d = (remaining != '0) ? REQ : PAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes decoded from the current state
  always_comb begin
    fifo_rd     = 1'b0;
    block_valid = 1'b0;
    case (state_q)
      REQ:     fifo_rd     = !fifo_empty;
      EMIT:    block_valid = 1'b1;
      default: ;
    endcase
  end

  // Block image with the captured FIFO byte dropped into the current slot
  always_comb begin
    cap_block = block_data;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (IDX_W'(i) == byte_idx) begin
        cap_block[8*i +: 8] = fifo_dout;
      end
    end
  end

  // Block image after padding: DS at the cursor, zeros after it, 0x80 OR'd into the top byte
  always_comb begin
    pad_block = block_data;
    for (int i = 0; i < RATE_BYTES; i++) begin
      if (IDX_W'(i) == byte_idx) begin
        pad_block[8*i +: 8] = ds;
      end else if (IDX_W'(i) > byte_idx) begin
        pad_block[8*i +: 8] = 8'h00;
      end
    end
    pad_block[DATA_W-1 -: 8] = pad_block[DATA_W-1 -: 8] | 8'h80;
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      block_data <= '0;
      byte_idx   <= '0;
      remaining  <= '0;
      block_last <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining  <= msg_len;
            byte_idx   <= '0;
            block_data <= '0;
            block_last <= 1'b0;
            busy       <= 1'b1;
          end
        end
        CAP: begin
          block_data <= cap_block;
          byte_idx   <= byte_idx + 1'b1;
          remaining  <= remaining - 1'b1;
        end
        PAD: begin
          block_data <= pad_block;
          block_last <= 1'b1;
        end
        EMIT: begin
          if (block_ready) begin
            if (block_last) begin
              done       <= 1'b1;
              busy       <= 1'b0;
              block_last <= 1'b0;
            end else begin
              block_data <= '0;
              byte_idx   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// Self-checking bench for sha3_absorb_ctrl: random message bytes, random FIFO stalls and
// back-pressure, checked against padded-message reference blocks.
`timescale 1ns/1ps
module tb_sha3_absorb_ctrl;

  localparam int unsigned R  = 72;
  localparam int unsigned LW = 16;
  localparam int unsigned DW = 8 * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] msg_len;
  logic [7:0]    fifo_dout = 8'h00;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] block_data;
  logic          block_valid;
  logic          block_ready;
  logic          block_last;
  logic          busy;
  logic          done;
`ifdef SHA3_ABSORB_SHAKE_EN
  logic          shake_mode = 1'b0;
`endif

  int n_cmp    = 0;
  int n_bad    = 0;
  int rd_count = 0;
  int viol     = 0;
  byte unsigned q[$];

  always #5 clk = ~clk;

  sha3_absorb_ctrl #(.RATE_BYTES(R), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .msg_len     (msg_len),
`ifdef SHA3_ABSORB_SHAKE_EN
    .shake_mode  (shake_mode),
`endif
    .fifo_dout   (fifo_dout),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last),
    .busy        (busy),
    .done        (done)
  );

  // FIFO model: read data appears the cycle after the strobe; illegal strobes are tallied
  always @(posedge clk) begin
    if (fifo_rd) begin
      rd_count++;
      if (q.size() != 0) fifo_dout <= q.pop_front();
      else viol++;
      if (fifo_empty || block_valid) viol++;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One complete message: reference blocks come from the padded byte stream
  task automatic run_msg(input int len, input bit fixed, input int stall_pct, input int nready_pct);
    byte unsigned pad[$];
    logic [DW-1:0] exp_blk;
    logic [DW-1:0] hold;
    logic [7:0]    ds;
    bit            sm;
    bit            seen;
    int            nblk;
    int            b;
    int            cyc;
    int            budget;
    sm = 1'b0;
`ifdef SHA3_ABSORB_SHAKE_EN
    sm = 1'($urandom_range(0, 1));
`endif
    ds = sm ? 8'h1F : 8'h06;
    for (int i = 0; i < len; i++) begin
      byte unsigned v;
      v = fixed ? 8'(8'h61 + i) : 8'($urandom);
      pad.push_back(v);
      q.push_back(v);
    end
    nblk = len / R + 1;
    pad.push_back(ds);
    while (pad.size() < nblk * R) pad.push_back(8'h00);
    pad[nblk*R-1] = pad[nblk*R-1] | 8'h80;
    rd_count = 0;

    @(negedge clk);
    start   = 1'b1;
    msg_len = LW'(len);
`ifdef SHA3_ABSORB_SHAKE_EN
    shake_mode = sm;
`endif
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", DW'(busy), DW'(1));

    b      = 0;
    seen   = 1'b0;
    cyc    = 0;
    budget = 10 * len + 200 * nblk + 100;
    while (b < nblk && cyc < budget) begin
      fifo_empty  = (q.size() == 0) || ($urandom_range(0, 99) < stall_pct);
      block_ready = ($urandom_range(0, 99) >= nready_pct);
      if (block_valid) begin
        if (!seen) begin
          for (int j = 0; j < R; j++) exp_blk[8*j +: 8] = pad[b*R + j];
          check($sformatf("len%0d_blk%0d_data", len, b), block_data, exp_blk);
          check($sformatf("len%0d_blk%0d_last", len, b), DW'(block_last), DW'(b == nblk - 1));
          hold = block_data;
          seen = 1'b1;
        end else begin
          check("data_hold", block_data, hold);
        end
        if (block_ready) begin
          b++;
          seen = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("len%0d_blocks_before_timeout", len), DW'(b), DW'(nblk));
    block_ready = 1'b0;
    fifo_empty  = 1'b1;
    check("done_pulse", DW'(done), DW'(1));
    check("busy_cleared", DW'(busy), DW'(0));
    check("valid_cleared", DW'(block_valid), DW'(0));
    @(negedge clk);
    check("done_one_cycle", DW'(done), DW'(0));
    check($sformatf("len%0d_read_count", len), DW'(rd_count), DW'(len));
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    msg_len     = '0;
    fifo_empty  = 1'b1;
    block_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_valid", DW'(block_valid), DW'(0));
    check("rst_last", DW'(block_last), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_fifo_rd", DW'(fifo_rd), DW'(0));
    check("rst_data", block_data, '0);
    rst_n = 1'b1;

    run_msg(0, 1'b0, 0, 0);
    run_msg(3, 1'b1, 0, 0);
    run_msg(71, 1'b0, 20, 20);
    run_msg(72, 1'b0, 0, 0);
    run_msg(72, 1'b0, 40, 90);
    run_msg(143, 1'b0, 25, 50);
    run_msg(144, 1'b0, 10, 30);
    for (int k = 0; k < 4; k++) run_msg(int'($urandom_range(0, 220)), 1'b0, 30, 40);

    // Abandon a message mid-block with reset
    @(negedge clk);
    start   = 1'b1;
    msg_len = LW'(50);
    for (int i = 0; i < 50; i++) q.push_back(8'($urandom));
    @(negedge clk);
    start = 1'b0;
    repeat (20) begin
      fifo_empty = (q.size() == 0);
      @(negedge clk);
    end
    fifo_empty = 1'b1;
    rst_n      = 1'b0;
    @(negedge clk);
    check("midrst_busy", DW'(busy), DW'(0));
    check("midrst_valid", DW'(block_valid), DW'(0));
    check("midrst_data", block_data, '0);
    check("midrst_fifo_rd", DW'(fifo_rd), DW'(0));
    rst_n = 1'b1;
    q.delete();
    run_msg(1, 1'b0, 0, 0);

    check("fifo_rd_protocol_violations", DW'(viol), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
